// File: rtl/id_imm_stage.sv
// Decode-side stage: splits MIPS instruction fields, builds the extended immediate,
// and presents them through a 2-entry skid buffer with a wrapping transfer counter.
//
// state    | meaning
// ST_EMPTY | no entry buffered, outputs invalid
// ST_ONE   | main register M holds the head entry
// ST_TWO   | M holds head, skid register S holds the next entry, input stalled
module id_imm_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [31:0]      imm,
  output logic [1:0]       imm_kind,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_in_ready;
  logic [31:0]      r_m_instr;
  logic [1:0]       r_m_kind;
  logic [31:0]      r_m_imm;
  logic [31:0]      r_s_instr;
  logic [1:0]       r_s_kind;
  logic [31:0]      r_s_imm;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [1:0]       w_kind;
  logic [31:0]      w_imm;
  logic             w_load_m;
  logic             w_load_s;
  logic             w_m_from_s;
  logic             w_xfer;

  always_comb begin
    w_kind = 2'd0;
    w_imm  = {{16{instr[15]}}, instr[15:0]};
    case (instr[31:26])
      6'h0F: begin
        w_kind = 2'd2;
        w_imm  = {instr[15:0], 16'h0000};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_kind = 2'd1;
        w_imm  = {16'h0000, instr[15:0]};
      end
      6'h02, 6'h03: begin
        w_kind = 2'd3;
        w_imm  = {6'b0, instr[25:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_load_m   = 1'b0;
    w_load_s   = 1'b0;
    w_m_from_s = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (in_valid) begin
          w_load_m = 1'b1;
          w_next   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_valid && out_ready) begin
          w_load_m = 1'b1;
        end else if (in_valid) begin
          w_load_s = 1'b1;
          w_next   = ST_TWO;
        end else if (out_ready) begin
          w_next   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          w_m_from_s = 1'b1;
          w_next     = ST_ONE;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
    // Redirect kills everything, including an entry offered this cycle
    if (flush) begin
      w_next     = ST_EMPTY;
      w_load_m   = 1'b0;
      w_load_s   = 1'b0;
      w_m_from_s = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_instr <= 32'h0;
      r_m_kind  <= 2'd0;
      r_m_imm   <= 32'h0;
      r_s_instr <= 32'h0;
      r_s_kind  <= 2'd0;
      r_s_imm   <= 32'h0;
    end else begin
      if (w_load_m) begin
        r_m_instr <= instr;
        r_m_kind  <= w_kind;
        r_m_imm   <= w_imm;
      end else if (w_m_from_s) begin
        r_m_instr <= r_s_instr;
        r_m_kind  <= r_s_kind;
        r_m_imm   <= r_s_imm;
      end
      if (w_load_s) begin
        r_s_instr <= instr;
        r_s_kind  <= w_kind;
        r_s_imm   <= w_imm;
      end
    end
  end

  assign w_xfer = (r_state != ST_EMPTY) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xfer_cnt <= '0;
    end else if (w_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign op        = r_m_instr[31:26];
  assign rs        = r_m_instr[25:21];
  assign rt        = r_m_instr[20:16];
  assign rd        = r_m_instr[15:11];
  assign shamt     = r_m_instr[10:6];
  assign funct     = r_m_instr[5:0];
  assign imm       = r_m_imm;
  assign imm_kind  = r_m_kind;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: doc/id_imm_stage.md
Name: id_imm_stage

Overview:
- Decode-side pipeline stage of the MIPS core. Sits between instruction fetch and the execute datapath.
- Accepts 32-bit instructions over a valid/ready handshake and splits out the register and function fields.
- Generates the 32-bit immediate that the ALU B-mux and branch/jump logic consume: sign-extend, zero-extend, upper (lui, imm<<16) or jump-target form.
- Output is registered through a 2-entry skid buffer so that in_ready comes from a flop and timing is isolated on both sides. Includes a wrapping transfer counter.

Parameters:
- CNT_W, 16, width of the accepted-output transfer counter xfer_cnt.

Ports:
- clk        input   1      rising-edge clock
- reset      input   1      asynchronous, active-high reset
- flush      input   1      synchronous kill of all buffered entries (branch/jump redirect)
- in_valid   input   1      instr is valid
- in_ready   output  1      stage can accept instr this cycle
- instr      input   32     raw MIPS instruction
- out_valid  output  1      output fields valid
- out_ready  input   1      downstream accepts output this cycle
- op         output  6      instr[31:26]
- rs         output  5      instr[25:21]
- rt         output  5      instr[20:16]
- rd         output  5      instr[15:11]
- shamt      output  5      instr[10:6]
- funct      output  6      instr[5:0]
- imm        output  32     extended immediate
- imm_kind   output  2      0=sign, 1=zero, 2=upper, 3=jump
- xfer_cnt   output  CNT_W  count of completed output transfers (out_valid & out_ready)

Behaviour:
- Extension is decoded on op at input and stored with the entry. Stored width per entry: 32-bit instr plus 2-bit kind plus 32-bit imm.
  - op 0x0F (lui): kind 2, imm = {instr[15:0], 16'h0000}.
  - op 0x0C/0x0D/0x0E (andi/ori/xori): kind 1, imm = {16'h0, instr[15:0]}.
  - op 0x02/0x03 (j/jal): kind 3, imm = {6'b0, instr[25:0]}.
  - All other ops, including R-type 0x00: kind 0, imm = {{16{instr[15]}}, instr[15:0]}.
- Storage is a main register M (drives the outputs) and a skid register S. A state machine tracks occupancy:
  - EMPTY: out_valid=0, in_ready=1. in_valid → load M, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - in_valid & out_ready → load M with new entry, stay ONE.
    - in_valid & !out_ready → load S, go to TWO.
    - !in_valid & out_ready → EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0; in_valid is ignored.
    - out_ready → M <= S, go to ONE.
    - Otherwise hold.
- in_ready is a registered signal equal to (state != TWO). It has no combinational path from out_ready.
- Order is strictly FIFO. No entry is ever dropped or duplicated.
- Latency: an input accepted in EMPTY appears on the outputs the next cycle.
- Output fields are held stable while out_valid=1 & out_ready=0.
- Output fields are don't-care when out_valid=0. The implementation keeps the last values; only out_valid is checked.
- flush, when high, has priority over everything else:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - An in_valid in the same cycle is discarded.
  - A transfer in the flush cycle (out_valid & out_ready) still counts.
- xfer_cnt increments by 1 on each cycle with out_valid & out_ready. It wraps from 2^CNT_W-1 to 0. It is not cleared by flush.
- Reset (async, any cycle, including mid-transfer):
  - State EMPTY, out_valid=0, in_ready=1, xfer_cnt=0.
  - M, S and all field outputs = 0, imm_kind = 0.
- On the first edge after reset deasserts, normal operation resumes.

Test Plan:
- Extension by opcode, one instr per cycle, out_ready=1:
  - 0x3C081234 → imm 0x12340000, kind 2, rt 8.
  - 0x2008FFFF → imm 0xFFFFFFFF, kind 0.
  - 0x3408FFFF → imm 0x0000FFFF, kind 1.
  - 0x08000010 → imm 0x00000010, kind 3.
  - 0x01095020 → rs 8, rt 9, rd 10, funct 0x20.
- Backpressure, out_ready=0, send A, B, C back-to-back:
  - A and B are accepted; in_ready=0 the cycle after B is accepted; C is held by the source.
  - Raise out_ready: outputs are A, then B, then C, with no gaps once C is accepted. xfer_cnt=3.
- Flush in TWO, with A and B buffered and in_valid=1 on D:
  - Next cycle out_valid=0 and in_ready=1.
  - D is not seen. xfer_cnt is unchanged.
- Async reset mid-stream, with reset asserted between edges while in TWO:
  - Outputs go to 0 immediately: out_valid=0, xfer_cnt=0.
  - After release, instr 0x3C01ABCD → imm 0xABCD0000.
- Counter wrap with CNT_W=4: 17 transfers → xfer_cnt reads 1.
- Random valid/ready toggling for 1000 instructions:
  - Scoreboard confirms in-order, loss-free delivery with correct imm/kind.
  - xfer_cnt equals the delivered count mod 2^CNT_W.
